ps2_kbd_rx: RTL
===============

# ps2_kbd_rx

PS/2 keyboard receiver and scancode prefix decoder for the BK-0010 keyboard path. It deserialises PS/2 device-to-host frames and tracks the E0, F0 and E1 prefixes and the left-shift state. It emits one strobe per make code, carrying `code`, `e0` and `shift`, which feed the combinational scancode-to-ASCII translator downstream.

## Interface
- `FILTER_LEN`, default 4: consecutive equal synchronised samples required to accept a new `ps2_clk` level.
- `TIMEOUT`, default 5000: idle `clk` cycles between bits that abort a partial frame.
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: PS/2 clock line, asynchronous to `clk`.
- `ps2_dat` in 1: PS/2 data line, asynchronous to `clk`.
- `code` out 8: scancode of the last make event.
- `e0` out 1: last make code was E0-prefixed.
- `shift` out 1: left shift (0x12, no E0) held. 0x59 (RShift) is a normal key and does not affect `shift`.
- `strobe` out 1: one-cycle pulse; `code`/`e0`/`shift` are valid in that cycle.
- `key_down` out 1: level, high from a make until the break of the same `{e0,code}`.
- `err` out 1: one-cycle pulse on frame error or timeout.

## Operation
- **Input conditioning**
  - Both lines pass through 2-FF synchronisers.
  - `ps2_clk` then passes through a FILTER_LEN-sample glitch filter.
  - A bit is sampled from synchronised `ps2_dat` on each filtered falling edge.
- **Frame FSM**
  - IDLE: start bit 0 → DATA. Start bit 1 → stay in IDLE, no error.
  - DATA: 8 bits, LSB first, 3-bit counter → PARITY.
  - PARITY → STOP.
  - STOP: stop bit 1 → byte valid, return to IDLE. Stop bit 0 → `err`, return to IDLE.
- **Timeout**
  - A counter clears on every filtered edge and counts only outside IDLE.
  - Reaching TIMEOUT → `err` pulse, FSM to IDLE.
  - A filtered edge in the same cycle as the terminal count wins: no error.
- **Byte decoder**, applied to each valid byte:
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: discarded; pending flags unchanged.
  - 0xE1: discard the next 7 bytes (Pause sequence), using a 3-bit skip counter.
  - 0xE0: set `e0_pend`.
  - 0xF0: set `brk_pend`.
  - Other byte with `brk_pend`:
    - 0x12 without `e0_pend` → `shift`=0.
    - `{e0_pend,byte}` equal to `{e0,code}` → `key_down`=0.
    - No strobe in either case. Clear both pending flags.
  - Other byte without `brk_pend`:
    - 0x12 without `e0_pend` → `shift`=1, no strobe.
    - E0 12 (fake shift) → discarded.
    - Otherwise `code`=byte, `e0`=`e0_pend`, `key_down`=1, `strobe` pulses. Clear pending flags.
    - Typematic repeats of a held key strobe again.
- Any `err` clears `e0_pend`, `brk_pend` and the skip counter.
- `code`/`e0` hold their values until the next make event.

## Timing
- Reset values:
  - `code`=0x00, `e0`=0, `shift`=0, `strobe`=0, `key_down`=0, `err`=0.
  - FSM in IDLE; pending flags, skip counter and timeout counter cleared.
- Reset asserted mid-frame: the partial frame is lost. The first frame after reset release decodes normally.
- Filtered edge latency: 2 sync stages + FILTER_LEN cycles after the `ps2_clk` pin falls.
- The stop-bit edge is accepted in cycle k:
  - In cycle k+1, `strobe`/`err` are high for exactly one cycle.
  - `shift`, `key_down`, `code` and `e0` update at k+1.
- `strobe` and `err` are never high in the same cycle.
- The downstream translator needs no handshake. It samples `code`/`e0`/`shift` while `strobe`=1.

## Configuration
- `KBD_PARITY_CHECK_EN` defined:
  - An even-parity frame (data+parity) gives an `err` pulse in the cycle after the stop-bit edge.
  - The byte is discarded and pending flags are cleared.
- Undefined: the parity bit is sampled and ignored; the frame is accepted if the start and stop bits are valid.

## Test plan
- Frame 0x1C, parity 0, stop 1 → `strobe` one cycle, `code`=0x1C, `e0`=0, `shift`=0, `key_down`=1. Then F0 1C → `key_down`=0, no strobe.
- Bytes 12, 1C, F0 1C, F0 12 → `shift`=1 before the `strobe` for 0x1C; the strobe carries `shift`=1. After F0 12, `shift`=0; no strobe for either 0x12 byte.
- Bytes E0 75 → `strobe`, `code`=0x75, `e0`=1. Bytes E0 F0 75 → `key_down`=0. Bytes E0 12 → no strobe, `shift`=0.
- Frame 0x1C with parity 1:
  - With `KBD_PARITY_CHECK_EN`: `err` pulse, no strobe.
  - Without it: `strobe` with `code`=0x1C.
- Stop `ps2_clk` after 5 data bits, wait TIMEOUT+1 cycles → one `err` pulse. The next frame 0x29 → `strobe`, `code`=0x29.
- E1 14 77 E1 F0 14 F0 77 → no strobe, no err. Then assert `reset` mid-way through a frame → all outputs 0; the following frame 0x16 → `strobe`, `code`=0x16.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver and scancode prefix decoder.
// Deserialises device-to-host frames, tracks E0/F0/E1 prefixes and left shift,
// and emits one strobe per make code for the downstream ASCII translator.
//
// Ports:
//   clk       system clock (single domain)
//   reset     asynchronous active-high reset
//   ps2_clk   PS/2 clock line (asynchronous)
//   ps2_dat   PS/2 data line (asynchronous)
//   code      scancode of the last make event
//   e0        last make code was E0-prefixed
//   shift     left shift (0x12 without E0) held
//   strobe    one-cycle pulse, code/e0/shift valid
//   key_down  high from a make until the break of the same {e0,code}
//   err       one-cycle pulse on frame error or timeout
//
// Optional feature: define KBD_PARITY_CHECK_EN to reject frames whose
// data+parity bits have even parity.
module ps2_kbd_rx #(
   parameter int unsigned FILTER_LEN = 4,
   parameter int unsigned TIMEOUT    = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] code,
   output logic       e0,
   output logic       shift,
   output logic       strobe,
   output logic       key_down,
   output logic       err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          filt;
   logic [FW-1:0] fcnt;
   logic          edge_acc;
   logic          fall;

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [TW-1:0] tcnt;
   logic          e0_pend;
   logic          brk_pend;
   logic [2:0]    skip;
`ifdef KBD_PARITY_CHECK_EN
   logic          par_bit;
`endif

   // Lines idle high, so the synchronisers reset to 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
      end
   end

   // A new level is accepted on the FILTER_LEN-th consecutive differing sample.
   always_comb begin
      edge_acc = (clk_sync[1] != filt) && (fcnt == FW'(FILTER_LEN - 1));
      fall     = edge_acc && !clk_sync[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt <= 1'b1;
         fcnt <= '0;
      end else if (clk_sync[1] != filt) begin
         if (edge_acc) begin
            filt <= clk_sync[1];
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end else begin
         fcnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         tcnt     <= '0;
         e0_pend  <= 1'b0;
         brk_pend <= 1'b0;
         skip     <= '0;
         code     <= '0;
         e0       <= 1'b0;
         shift    <= 1'b0;
         strobe   <= 1'b0;
         key_down <= 1'b0;
         err      <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         strobe <= 1'b0;
         err    <= 1'b0;

         // A filtered edge clears the counter, so it beats a same-cycle terminal count.
         if (edge_acc) begin
            tcnt <= '0;
         end else if (state != IDLE) begin
            if (tcnt == TW'(TIMEOUT - 1)) begin
               tcnt     <= '0;
               state    <= IDLE;
               err      <= 1'b1;
               e0_pend  <= 1'b0;
               brk_pend <= 1'b0;
               skip     <= '0;
            end else begin
               tcnt <= tcnt + TW'(1);
            end
         end

         if (fall) begin
            case (state)
               IDLE: begin
                  if (!dat_sync[1]) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {dat_sync[1], shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                  par_bit <= dat_sync[1];
`endif
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!dat_sync[1]
`ifdef KBD_PARITY_CHECK_EN
                      || !(^{shreg, par_bit})
`endif
                     ) begin
                     err      <= 1'b1;
                     e0_pend  <= 1'b0;
                     brk_pend <= 1'b0;
                     skip     <= '0;
                  end else if (skip != 3'd0) begin
                     skip <= skip - 3'd1;
                  end else if (shreg == 8'hAA || shreg == 8'hFA || shreg == 8'hEE ||
                               shreg == 8'hFE || shreg == 8'h00 || shreg == 8'hFF) begin
                     // controller responses: ignored, prefixes kept
                  end else if (shreg == 8'hE1) begin
                     skip <= 3'd7;
                  end else if (shreg == 8'hE0) begin
                     e0_pend <= 1'b1;
                  end else if (shreg == 8'hF0) begin
                     brk_pend <= 1'b1;
                  end else if (brk_pend) begin
                     if (shreg == 8'h12 && !e0_pend) shift <= 1'b0;
                     if ({e0_pend, shreg} == {e0, code}) key_down <= 1'b0;
                     e0_pend  <= 1'b0;
                     brk_pend <= 1'b0;
                  end else if (shreg == 8'h12) begin
                     // plain 12 is left shift; E0 12 is the fake shift and is dropped
                     if (!e0_pend) shift <= 1'b1;
                     e0_pend <= 1'b0;
                  end else begin
                     code     <= shreg;
                     e0       <= e0_pend;
                     key_down <= 1'b1;
                     strobe   <= 1'b1;
                     e0_pend  <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
